img_frame_seq: RTL and testbench
================================

Name: img_frame_seq

Overview:
Frame sequencer for the image line buffer. Parses a 4-byte little-endian length header from the UART RX byte stream and programs the buffer length. Streams the payload into the buffer write port, then drains the buffer to the UART TX one byte at a time, paced by TX busy. Sits between uart_rx/uart_tx and the image buffer in the top level.

Parameters:
D_BITS, 8, byte/data width of RX, TX and buffer ports
N, 400, buffer depth; maximum legal frame length
TO_CYCLES, 1_000_000, RX inter-byte timeout in i_clk cycles (used only with the optional feature)

Ports:
i_clk  in  1  system clock
reset  in  1  synchronous, active-low reset
rx_data  in  D_BITS  received byte
rx_valid  in  1  one-cycle strobe; rx_data valid
tx_busy  in  1  UART TX is transmitting
tx_start  out  1  one-cycle strobe; tx_data valid
tx_data  out  D_BITS  byte to transmit
buf_len  out  32  frame length driven to the buffer
buf_wr_en  out  1  buffer write enable
buf_wr_data  out  D_BITS  buffer write data
buf_rd_en  out  1  buffer read enable
buf_rd_data  in  D_BITS  buffer read data, valid 1 cycle after buf_rd_en
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse after the last TX byte is issued
err_len  out  1  one-cycle pulse when a header is illegal

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; all outputs 0; byte counters 0; buf_len=0.
- States:
  - IDLE: on rx_valid, store rx_data as len[7:0]; hdr_cnt=1; go to HDR.
  - HDR: on each rx_valid, store into len byte hdr_cnt; after the 4th byte, evaluate len.
    - len==0 or len>N: pulse err_len and return to IDLE. buf_len is unchanged.
    - Otherwise: buf_len<=len, wr_cnt=0, go to LOAD.
  - LOAD: on rx_valid, buf_wr_en=1 and buf_wr_data=rx_data in the same cycle (combinational pass-through, gated by state), wr_cnt++. When the write with wr_cnt==len-1 occurs, set rd_cnt=0 and go to RD_REQ.
  - RD_REQ: if !tx_busy, assert buf_rd_en for one cycle and go to RD_DATA.
  - RD_DATA: register tx_data<=buf_rd_data, pulse tx_start, rd_cnt++, go to GAP.
  - GAP: wait exactly one cycle, which lets tx_busy rise. If rd_cnt==len, pulse frame_done and go to IDLE; else go to RD_REQ.
- rx_valid outside IDLE/HDR/LOAD is ignored. Bytes received during the drain are dropped, not queued.
- Throughput: at most one TX byte per 3 cycles plus the TX busy time.
- buf_wr_en and buf_rd_en are never high in the same cycle.
- Reset mid-frame: immediate return to IDLE. The buffer's own counters are reset by the top level from the same reset.
- Counters are 32-bit; a legal len fits $clog2(N)+1 bits, and comparisons use the full 32 bits.

Optional Feature:
RX_TIMEOUT_EN
- Defined: an idle counter runs in HDR and LOAD and clears on every rx_valid. Reaching TO_CYCLES pulses err_len and returns to IDLE, abandoning the partial frame.
- Undefined: no counter; HDR and LOAD wait indefinitely.

Decomposition:
- Package img_pkg holds:
  - the state_t enum (IDLE, HDR, LOAD, RD_REQ, RD_DATA, GAP), logic [2:0];
  - localparam HDR_BYTES=4;
  - shared with the buffer: D_BITS default and N default.
- No sub-module needed; the timeout counter is inline, guarded by `ifdef.

Test Plan:
- Header 03 00 00 00, payload AA BB CC, tx_busy low -> buf_len=3; 3 writes; tx_start ×3 with tx_data AA, BB, CC, each 3 cycles apart; then frame_done.
- Header 00 00 00 00 -> err_len pulse, busy=0 next cycle, no buf_wr_en.
- Header 91 01 00 00 (len 401 > N) -> err_len, no writes; a following legal frame completes normally.
- len=2, tx_busy held high 50 cycles after each tx_start -> buf_rd_en only when tx_busy=0; exactly 2 tx_start; frame_done.
- reset=0 asserted during LOAD after 1 of 3 bytes -> all outputs 0 next cycle; a new frame 01 00 00 00 55 transmits 55.
- With RX_TIMEOUT_EN and TO_CYCLES=100: send 2 header bytes, then idle 100 cycles -> err_len pulse, state IDLE.

Source files
------------

// File: rtl/img_pkg.sv
// ============================================================================
// Module  : img_pkg
// Brief   : Shared types and defaults for the image frame sequencer and buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package img_pkg;

  localparam int IMG_D_BITS = 8;
  localparam int IMG_N      = 400;
  localparam int HDR_BYTES  = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    LOAD    = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    GAP     = 3'd5
  } state_t;

  // A frame must carry at least one byte and fit in the buffer.
  function automatic logic len_legal(input logic [31:0] len, input logic [31:0] max_len);
    return (len != 32'd0) && (len <= max_len);
  endfunction

endpackage

`default_nettype wire

// File: rtl/img_frame_seq.sv
// ============================================================================
// Module  : img_frame_seq
// Brief   : Parses a 4-byte LE length header from UART RX, loads the payload
//           into the line buffer, then drains it to UART TX paced by tx_busy.
//           Optional macro RX_TIMEOUT_EN adds an RX inter-byte timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module img_frame_seq
  import img_pkg::*;
#(
  parameter int D_BITS    = IMG_D_BITS,
  parameter int N         = IMG_N,
  parameter int TO_CYCLES = 1_000_000
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic [D_BITS-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [D_BITS-1:0] tx_data,
  output logic [31:0]       buf_len,
  output logic              buf_wr_en,
  output logic [D_BITS-1:0] buf_wr_data,
  output logic              buf_rd_en,
  input  logic [D_BITS-1:0] buf_rd_data,
  output logic              busy,
  output logic              frame_done,
  output logic              err_len
);

  if (TO_CYCLES < 1) begin : g_bad_to_cycles
    $error("TO_CYCLES must be at least 1");
  end

  state_t            state_q, state_d;
  logic [1:0]        hdr_cnt_q, hdr_cnt_d;
  logic [31:0]       len_q, len_d;
  logic [31:0]       buf_len_q, buf_len_d;
  logic [31:0]       wr_cnt_q, wr_cnt_d;
  logic [31:0]       rd_cnt_q, rd_cnt_d;
  logic [D_BITS-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              frame_done_q, frame_done_d;
  logic              err_len_q, err_len_d;
  logic              w_wr_en;
  logic              w_rd_en;
`ifdef RX_TIMEOUT_EN
  logic [31:0]       to_cnt_q, to_cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    hdr_cnt_d    = hdr_cnt_q;
    len_d        = len_q;
    buf_len_d    = buf_len_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    frame_done_d = 1'b0;
    err_len_d    = 1'b0;
    w_wr_en      = 1'b0;
    w_rd_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          len_d     = {24'd0, rx_data[7:0]};
          hdr_cnt_d = 2'd1;
          state_d   = HDR;
        end
      end
      HDR: begin
        if (rx_valid) begin
          case (hdr_cnt_q)
            2'd1:    len_d[15:8]  = rx_data[7:0];
            2'd2:    len_d[23:16] = rx_data[7:0];
            default: len_d[31:24] = rx_data[7:0];
          endcase
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'(HDR_BYTES - 1)) begin
            if (len_legal(len_d, 32'(N))) begin
              buf_len_d = len_d;
              wr_cnt_d  = 32'd0;
              state_d   = LOAD;
            end else begin
              err_len_d = 1'b1;
              state_d   = IDLE;
            end
          end
        end
      end
      LOAD: begin
        if (rx_valid) begin
          w_wr_en  = 1'b1;
          wr_cnt_d = wr_cnt_q + 32'd1;
          if (wr_cnt_q == len_q - 32'd1) begin
            rd_cnt_d = 32'd0;
            state_d  = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (!tx_busy) begin
          w_rd_en = 1'b1;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        // Buffer read data is valid here, one cycle after the read strobe.
        tx_data_d  = buf_rd_data;
        tx_start_d = 1'b1;
        rd_cnt_d   = rd_cnt_q + 32'd1;
        state_d    = GAP;
      end
      GAP: begin
        if (rd_cnt_q == len_q) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end else begin
          state_d = RD_REQ;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef RX_TIMEOUT_EN
    to_cnt_d = 32'd0;
    if ((state_q == HDR || state_q == LOAD) && !rx_valid) begin
      if (to_cnt_q == 32'(TO_CYCLES - 1)) begin
        err_len_d = 1'b1;
        state_d   = IDLE;
      end else begin
        to_cnt_d = to_cnt_q + 32'd1;
      end
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      hdr_cnt_q    <= 2'd0;
      len_q        <= 32'd0;
      buf_len_q    <= 32'd0;
      wr_cnt_q     <= 32'd0;
      rd_cnt_q     <= 32'd0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_len_q    <= 1'b0;
`ifdef RX_TIMEOUT_EN
      to_cnt_q     <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      hdr_cnt_q    <= hdr_cnt_d;
      len_q        <= len_d;
      buf_len_q    <= buf_len_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      frame_done_q <= frame_done_d;
      err_len_q    <= err_len_d;
`ifdef RX_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign buf_len     = buf_len_q;
  assign buf_wr_en   = w_wr_en;
  assign buf_wr_data = (state_q == LOAD) ? rx_data : '0;
  assign buf_rd_en   = w_rd_en;
  assign busy        = (state_q != IDLE);
  assign frame_done  = frame_done_q;
  assign err_len     = err_len_q;

endmodule

`default_nettype wire

// File: tb/tb_img_frame_seq.sv
// ============================================================================
// Module  : tb_img_frame_seq
// Brief   : Directed self-checking bench for img_frame_seq with a buffer and
//           UART TX busy model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_img_frame_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [31:0] buf_len;
  logic        buf_wr_en;
  logic [7:0]  buf_wr_data;
  logic        buf_rd_en;
  logic [7:0]  buf_rd_data = 8'd0;
  logic        busy;
  logic        frame_done;
  logic        err_len;

  img_frame_seq #(.D_BITS(8), .N(400), .TO_CYCLES(100)) dut (
    .i_clk       (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .buf_len     (buf_len),
    .buf_wr_en   (buf_wr_en),
    .buf_wr_data (buf_wr_data),
    .buf_rd_en   (buf_rd_en),
    .buf_rd_data (buf_rd_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_len     (err_len)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Buffer model: write/read pointers restart whenever the sequencer is idle.
  logic [7:0] mem [0:511];
  int wptr = 0;
  int rptr = 0;
  always @(posedge clk) begin
    if (!busy) begin
      wptr <= 0;
      rptr <= 0;
    end else begin
      if (buf_wr_en) begin
        mem[wptr] <= buf_wr_data;
        wptr      <= wptr + 1;
      end
      if (buf_rd_en) begin
        buf_rd_data <= mem[rptr];
        rptr        <= rptr + 1;
      end
    end
  end

  // UART TX model: busy for hold_cycles after each tx_start.
  int hold_cycles = 0;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_start && hold_cycles > 0) begin
      busy_cnt <= hold_cycles;
      tx_busy  <= 1'b1;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt <= 0;
      tx_busy  <= 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] tx_log[$];
  int tx_cyc[$];
  int wr_n = 0, fd_n = 0, err_n = 0, viol_busy = 0, viol_both = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (tx_start) begin
        tx_log.push_back(tx_data);
        tx_cyc.push_back(cyc);
      end
      if (buf_wr_en) wr_n++;
      if (frame_done) fd_n++;
      if (err_len) err_n++;
      if (buf_rd_en && tx_busy) viol_busy++;
      if (buf_rd_en && buf_wr_en) viol_both++;
    end
  end

  function automatic void clear_logs();
    tx_log.delete();
    tx_cyc.delete();
    wr_n = 0; fd_n = 0; err_n = 0; viol_busy = 0; viol_both = 0;
  endfunction

  function automatic logic [31:0] tx_at(input int i);
    return (i < tx_log.size()) ? {24'd0, tx_log[i]} : 32'hDEAD;
  endfunction

  function automatic int gap_at(input int i);
    return (i + 1 < tx_cyc.size()) ? tx_cyc[i+1] - tx_cyc[i] : -1;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] len);
    for (int i = 0; i < 4; i++) send_byte(8'(len >> (8 * i)));
  endtask

  task automatic wait_done(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (fd_n > 0) break;
    end
    check(tag, 32'(fd_n), 32'd1);
  endtask

  initial begin
    int bad;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_buf_len", buf_len, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_wr_rd_en", {30'd0, buf_wr_en, buf_rd_en}, 32'd0);
    check("rst_pulses", {30'd0, frame_done, err_len}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Basic 3-byte frame, TX idle
    clear_logs();
    send_hdr(32'd3);
    check("t1_buf_len", buf_len, 32'd3);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    wait_done("t1_done", 100);
    check("t1_wr_n", 32'(wr_n), 32'd3);
    check("t1_tx_n", 32'(tx_log.size()), 32'd3);
    check("t1_tx0", tx_at(0), 32'hAA);
    check("t1_tx1", tx_at(1), 32'hBB);
    check("t1_tx2", tx_at(2), 32'hCC);
    check("t1_gap0", 32'(gap_at(0)), 32'd3);
    check("t1_gap1", 32'(gap_at(1)), 32'd3);
    check("t1_rd_wr_overlap", 32'(viol_both), 32'd0);
    @(negedge clk);
    check("t1_idle", {31'd0, busy}, 32'd0);

    // Zero-length header
    clear_logs();
    send_hdr(32'd0);
    @(negedge clk);
    check("t2_err_len", {31'd0, err_len}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    check("t2_err_n", 32'(err_n), 32'd1);
    check("t2_wr_n", 32'(wr_n), 32'd0);
    check("t2_buf_len_kept", buf_len, 32'd3);

    // Oversized header (401), then a legal frame
    clear_logs();
    send_hdr(32'h0000_0191);
    repeat (5) @(negedge clk);
    check("t3_err_n", 32'(err_n), 32'd1);
    check("t3_wr_n", 32'(wr_n), 32'd0);
    check("t3_buf_len_kept", buf_len, 32'd3);
    clear_logs();
    send_hdr(32'd2);
    send_byte(8'h11); send_byte(8'h22);
    wait_done("t3_done", 100);
    check("t3_buf_len", buf_len, 32'd2);
    check("t3_tx0", tx_at(0), 32'h11);
    check("t3_tx1", tx_at(1), 32'h22);
    check("t3_err_after", 32'(err_n), 32'd0);

    // TX busy held for 50 cycles after each start
    clear_logs();
    hold_cycles = 50;
    send_hdr(32'd2);
    send_byte(8'h33); send_byte(8'h44);
    wait_done("t4_done", 400);
    check("t4_tx_n", 32'(tx_log.size()), 32'd2);
    check("t4_tx0", tx_at(0), 32'h33);
    check("t4_tx1", tx_at(1), 32'h44);
    check("t4_rd_while_busy", 32'(viol_busy), 32'd0);
    check("t4_paced", {31'd0, gap_at(0) >= 50}, 32'd1);
    hold_cycles = 0;
    repeat (60) @(negedge clk);

    // Reset during LOAD after one of three bytes
    clear_logs();
    send_hdr(32'd3);
    send_byte(8'h66);
    reset = 1'b0;
    @(posedge clk); #1;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_buf_len", buf_len, 32'd0);
    check("t5_outs", {27'd0, tx_start, buf_wr_en, buf_rd_en, frame_done, err_len}, 32'd0);
    reset = 1'b1;
    clear_logs();
    send_hdr(32'd1);
    send_byte(8'h55);
    wait_done("t5_done", 100);
    check("t5_tx_n", 32'(tx_log.size()), 32'd1);
    check("t5_tx0", tx_at(0), 32'h55);

    // Maximum legal length N=400
    clear_logs();
    send_hdr(32'd400);
    check("t6_buf_len", buf_len, 32'd400);
    for (int i = 0; i < 400; i++) send_byte(8'(i));
    wait_done("t6_done", 2000);
    check("t6_wr_n", 32'(wr_n), 32'd400);
    check("t6_tx_n", 32'(tx_log.size()), 32'd400);
    bad = 0;
    for (int i = 0; i < 400; i++) if (tx_at(i) != 32'(i[7:0])) bad++;
    check("t6_tx_data", 32'(bad), 32'd0);
    check("t6_tx_last", tx_at(399), 32'h8F);

`ifdef RX_TIMEOUT_EN
    // Inter-byte timeout of 100 cycles in HDR
    clear_logs();
    send_byte(8'h05); send_byte(8'h00);
    repeat (90) @(negedge clk);
    check("t7_wait_busy", {31'd0, busy}, 32'd1);
    check("t7_no_err_yet", 32'(err_n), 32'd0);
    repeat (15) @(negedge clk);
    check("t7_err_n", 32'(err_n), 32'd1);
    check("t7_idle", {31'd0, busy}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
